bin2bcd_seq: RTL

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_pkg.sv | 13 +
 rtl/bin2bcd_digit.sv | 18 +
 rtl/bin2bcd_seq.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// the FSM state encoding and the BCD digit width.
package bin2bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bin2bcd_digit.sv
// Combinational double-dabble digit corrector: adds 3 to a BCD digit
// of 5 or more so that the following left shift carries correctly.
module bin2bcd_digit
    import bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    // Correct the digit ahead of the shift.
    always_comb begin
        dout = din;
        if (din >= BCD_DIGIT_W'(5)) begin
            dout = din + BCD_DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 (double-dabble) binary-to-BCD converter.
// One operand is accepted in IDLE, converted over W SHIFT cycles, and the
// result is held in DONE until the consumer takes it.
// Optional leading-zero blanking is enabled by defining BIN2BCD_SEQ_LZB_EN;
// without it the blank port is tied to zero.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int W = 18,
    parameter int D = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             bin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BCD_DIGIT_W*D-1:0] bcd,
    output logic [D-1:0]             blank,
    output logic                     busy
);

    localparam int CW = $clog2(W + 1);
    localparam int AW = BCD_DIGIT_W * D;

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    if (W < 4 || W > 32) begin : g_bad_w
        $error("bin2bcd_seq: W=%0d outside legal range 4..32", W);
    end

    if (pow10(D) <= ((64'd1 << W) - 64'd1)) begin : g_bad_d
        $error("bin2bcd_seq: D=%0d digits cannot hold a %0d-bit value", D, W);
    end

    state_t         state, state_nxt;
    logic [AW-1:0]  acc;
    logic [AW-1:0]  acc_adj;
    logic [AW-1:0]  acc_nxt;
    logic [W-1:0]   opr;
    logic [CW-1:0]  cnt;
    logic [AW-1:0]  bcd_q;
    logic           accept;
    logic           last_iter;

    assign accept    = (state == IDLE) && in_valid;
    assign last_iter = (cnt == CW'(1));

    for (genvar i = 0; i < D; i++) begin : g_digit
        bin2bcd_digit u_digit (
            .din  (acc[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .dout (acc_adj[BCD_DIGIT_W*i +: BCD_DIGIT_W])
        );
    end

    // Corrected accumulator shifted left, pulling in the operand MSB.
    assign acc_nxt = {acc_adj[AW-2:0], opr[W-1]};

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and handshake/status outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Working accumulator and operand shift register (data only, no reset).
    always_ff @(posedge clk) begin
        if (accept) begin
            opr <= bin;
            acc <= '0;
        end else if (state == SHIFT) begin
            acc <= acc_nxt;
            opr <= {opr[W-2:0], 1'b0};
        end
    end

    // Iteration counter and result register; the result only changes on
    // the final shift so partial sums never reach the bcd port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            bcd_q <= '0;
        end else begin
            if (accept) begin
                cnt <= CW'(W);
            end else if (state == SHIFT) begin
                cnt <= cnt - CW'(1);
            end
            if (state == SHIFT && last_iter) begin
                bcd_q <= acc_nxt;
            end
        end
    end

    assign bcd = bcd_q;

`ifdef BIN2BCD_SEQ_LZB_EN
    logic [D-1:0] blank_nxt;
    logic [D-1:0] blank_q;

    // Leading-zero flags of the final result, scanning down from the MSD.
    always_comb begin
        logic zrun;
        zrun      = 1'b1;
        blank_nxt = '0;
        for (int i = D - 1; i > 0; i--) begin
            zrun         = zrun & (acc_nxt[BCD_DIGIT_W*i +: BCD_DIGIT_W] == '0);
            blank_nxt[i] = zrun;
        end
    end

    // Blank flags registered alongside the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_q <= '0;
        end else if (state == SHIFT && last_iter) begin
            blank_q <= blank_nxt;
        end
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

endmodule
